// File: rtl/esaxi_mesh_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : esaxi_pkg
// Description : Shared constants and state type for the eMesh write/read
//               request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package esaxi_pkg;

  // eMesh packet width
  localparam int ESAXI_PW       = 104;
  // Consecutive write grants allowed while a read is pending
  localparam int ESAXI_MAX_HOLD = 8;

  // ARB: round-robin between inputs; WLOCK: write burst owns the output
  typedef enum logic [0:0] {
    ARB   = 1'b0,
    WLOCK = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/esaxi_mesh_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : esaxi_mesh_arb_if
// Description : Request inputs (write and read) and merged eMesh output of
//               the arbiter. master = request sources + downstream sink,
//               slave = arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface esaxi_mesh_arb_if
  import esaxi_pkg::*;
#(
  parameter int PW = ESAXI_PW
);
  logic          wr_access;
  logic [PW-1:0] wr_packet;
  logic          wr_lock;
  logic          wr_wait;
  logic          rd_access;
  logic [PW-1:0] rd_packet;
  logic          rd_wait;
  logic          tx_access;
  logic [PW-1:0] tx_packet;
  logic          tx_wait;

  modport master (
    output wr_access, wr_packet, wr_lock, rd_access, rd_packet, tx_wait,
    input  wr_wait, rd_wait, tx_access, tx_packet
  );

  modport slave (
    input  wr_access, wr_packet, wr_lock, rd_access, rd_packet, tx_wait,
    output wr_wait, rd_wait, tx_access, tx_packet
  );
endinterface
`default_nettype wire

// File: rtl/esaxi_mesh_arb_rr2.sv
`default_nettype none
// ============================================================================
// Module      : esaxi_rr2
// Description : Two-way round-robin grant. A lone requester always wins; on
//               contention the input not granted last wins. The pointer only
//               moves when the caller reports an accepted transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module esaxi_rr2 (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic req_wr,
  input  wire logic req_rd,
  input  wire logic advance,
  output logic      gnt_wr,
  output logic      gnt_rd
);

  // 1 when the last accepted grant went to the write input
  logic last_wr;

  // Grant selection from requests and last-grant pointer
  always_comb begin
    gnt_wr = req_wr & (~req_rd | ~last_wr);
    gnt_rd = req_rd & ~gnt_wr;
  end

  // Pointer starts at "read" so write wins the first contention
  always_ff @(posedge clk) begin
    if (rst) begin
      last_wr <= 1'b0;
    end else if (advance) begin
      last_wr <= gnt_wr;
    end
  end

endmodule
`default_nettype wire

// File: rtl/esaxi_mesh_arb.sv
`default_nettype none
// ============================================================================
// Module      : esaxi_mesh_arb
// Description : Merges write- and read-request eMesh packet streams onto a
//               single registered output. Round-robin between sources, locked
//               write bursts, and a hold limit that lets a pending read break
//               into a long locked burst.
// Revision    : 1.0 - initial release
// ============================================================================
module esaxi_mesh_arb
  import esaxi_pkg::*;
#(
  parameter int PW       = ESAXI_PW,
  parameter int MAX_HOLD = ESAXI_MAX_HOLD
) (
  input wire logic         clk,
  input wire logic         rst,
  esaxi_mesh_arb_if.slave  bus
);

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic [3:0]    hold;
  logic          tx_access_q;
  logic [PW-1:0] tx_packet_q;
  logic          load;
  logic          force_rd;
  logic          req_wr_m;
  logic          req_rd_m;
  logic          gnt_wr;
  logic          gnt_rd;
  logic          wr_acc;
  logic          rd_acc;

  // Output register can take a packet when empty or being drained
  assign load     = ~tx_access_q | ~bus.tx_wait;
  // Hold limit reached with a read still waiting: read goes next
  assign force_rd = bus.rd_access & (hold == HOLD_MAX);

  // Request masking: locked bursts shut out reads unless the hold limit hit
  always_comb begin
    req_wr_m = bus.wr_access & ~force_rd;
    req_rd_m = bus.rd_access & ((state == ARB) | force_rd);
  end

  esaxi_rr2 u_rr2 (
    .clk     (clk),
    .rst     (rst),
    .req_wr  (req_wr_m),
    .req_rd  (req_rd_m),
    .advance (wr_acc | rd_acc),
    .gnt_wr  (gnt_wr),
    .gnt_rd  (gnt_rd)
  );

  assign wr_acc      = load & gnt_wr & ~rst;
  assign rd_acc      = load & gnt_rd & ~rst;
  assign bus.wr_wait = ~wr_acc;
  assign bus.rd_wait = ~rd_acc;
  assign bus.tx_access = tx_access_q;
  assign bus.tx_packet = tx_packet_q;

  // Lock FSM next state: every accepted write's lock bit decides the state
  always_comb begin
    state_nxt = state;
    if (wr_acc) begin
      state_nxt = bus.wr_lock ? WLOCK : ARB;
    end
  end

  // Lock FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB;
    end else begin
      state <= state_nxt;
    end
  end

  // Count consecutive writes that starve a pending read
  always_ff @(posedge clk) begin
    if (rst || rd_acc || !bus.rd_access) begin
      hold <= 4'd0;
    end else if (wr_acc && hold != HOLD_MAX) begin
      hold <= hold + 4'd1;
    end
  end

  // Output register: load granted packet, drain, or hold under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_access_q <= 1'b0;
      tx_packet_q <= '0;
    end else if (load) begin
      tx_access_q <= wr_acc | rd_acc;
      if (wr_acc) begin
        tx_packet_q <= bus.wr_packet;
      end else if (rd_acc) begin
        tx_packet_q <= bus.rd_packet;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_esaxi_mesh_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_esaxi_mesh_arb
// Description : Directed self-checking bench for esaxi_mesh_arb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_esaxi_mesh_arb;
  import esaxi_pkg::*;

  localparam int PW = 104;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  esaxi_mesh_arb_if #(.PW(PW)) bus ();

  esaxi_mesh_arb #(.PW(PW), .MAX_HOLD(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] pk(input logic [31:0] v);
    pk = {{(PW-32){1'b0}}, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkp(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp2 [4];
    logic [31:0] w;
    logic [31:0] r;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.wr_access = 1'b1;
    bus.wr_packet = pk(32'hEE);
    bus.wr_lock   = 1'b0;
    bus.rd_access = 1'b1;
    bus.rd_packet = pk(32'hDD);
    bus.tx_wait   = 1'b0;

    // ---- reset: requests present but nothing accepted
    #2;
    chk1("rst_wr_wait", bus.wr_wait, 1'b1);
    chk1("rst_rd_wait", bus.rd_wait, 1'b1);
    tick();
    tick();
    chk1("rst_tx_access", bus.tx_access, 1'b0);
    chkp("rst_tx_packet", bus.tx_packet, pk(32'h0));

    // ---- single write 0xA1, latency 1
    rst = 1'b0;
    bus.rd_access = 1'b0;
    bus.wr_packet = pk(32'hA1);
    #1;
    chk1("t1_wr_wait", bus.wr_wait, 1'b0);
    chk1("t1_rd_wait_idle", bus.rd_wait, 1'b1);
    tick();
    bus.wr_access = 1'b0;
    chk1("t1_tx_access", bus.tx_access, 1'b1);
    chkp("t1_tx_packet", bus.tx_packet, pk(32'hA1));

    // ---- contention alternates W,R,W,R starting with W
    do_reset();
    exp2[0] = 32'h10; exp2[1] = 32'h20; exp2[2] = 32'h11; exp2[3] = 32'h21;
    w = 32'h10;
    r = 32'h20;
    bus.wr_access = 1'b1;
    bus.rd_access = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.wr_packet = pk(w);
      bus.rd_packet = pk(r);
      #1;
      chk1("t2_wr_wait", bus.wr_wait, (i % 2) == 1);
      chk1("t2_rd_wait", bus.rd_wait, (i % 2) == 0);
      tick();
      chkp("t2_tx_packet", bus.tx_packet, pk(exp2[i]));
      if ((i % 2) == 0) w = w + 1; else r = r + 1;
    end

    // ---- backpressure: 0x55 held for 3 cycles, then drain+load together
    bus.rd_access = 1'b0;
    bus.wr_packet = pk(32'h55);
    tick();
    chkp("t3_load55", bus.tx_packet, pk(32'h55));
    bus.tx_wait   = 1'b1;
    bus.wr_packet = pk(32'h66);
    bus.rd_access = 1'b1;
    bus.rd_packet = pk(32'h77);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("t3_wr_wait_bp", bus.wr_wait, 1'b1);
      chk1("t3_rd_wait_bp", bus.rd_wait, 1'b1);
      tick();
      chk1("t3_tx_access_bp", bus.tx_access, 1'b1);
      chkp("t3_tx_packet_bp", bus.tx_packet, pk(32'h55));
    end
    bus.tx_wait = 1'b0;
    #1;
    chk1("t3_rd_wait_rel", bus.rd_wait, 1'b0);
    chk1("t3_wr_wait_rel", bus.wr_wait, 1'b1);
    tick();
    chkp("t3_tx_after_rel", bus.tx_packet, pk(32'h77));
    bus.rd_access = 1'b0;
    tick();
    chkp("t3_tx_66", bus.tx_packet, pk(32'h66));
    bus.wr_access = 1'b0;
    tick();
    chk1("t3_idle_access", bus.tx_access, 1'b0);
    chkp("t3_idle_hold", bus.tx_packet, pk(32'h66));

    // ---- locked 4-beat burst with read pending, then read, then ARB
    do_reset();
    bus.wr_access = 1'b1;
    bus.rd_access = 1'b1;
    bus.rd_packet = pk(32'h30);
    for (int i = 0; i < 4; i++) begin
      bus.wr_packet = pk(32'h40 + i);
      bus.wr_lock   = (i < 3);
      #1;
      chk1("t4_rd_wait", bus.rd_wait, 1'b1);
      chk1("t4_wr_wait", bus.wr_wait, 1'b0);
      tick();
      chkp("t4_tx_wr", bus.tx_packet, pk(32'h40 + i));
    end
    bus.wr_access = 1'b0;
    bus.wr_lock   = 1'b0;
    #1;
    chk1("t4_rd_wait_after", bus.rd_wait, 1'b0);
    tick();
    chkp("t4_tx_rd", bus.tx_packet, pk(32'h30));
    bus.wr_access = 1'b1;
    bus.wr_packet = pk(32'h44);
    bus.rd_packet = pk(32'h31);
    tick();
    chkp("t4_arb_w", bus.tx_packet, pk(32'h44));
    bus.wr_packet = pk(32'h45);
    tick();
    chkp("t4_arb_r", bus.tx_packet, pk(32'h31));
    bus.wr_access = 1'b0;
    bus.rd_access = 1'b0;
    tick();

    // ---- 12-beat locked burst vs. MAX_HOLD=8: 8W, 1R, 4W
    do_reset();
    w = 32'h60;
    r = 32'h50;
    bus.wr_access = 1'b1;
    bus.rd_access = 1'b1;
    for (int k = 0; k < 13; k++) begin
      bus.wr_packet = pk(w);
      bus.wr_lock   = (w < 32'h6B);
      bus.rd_packet = pk(r);
      #1;
      chk1("t5_wr_wait", bus.wr_wait, k == 8);
      chk1("t5_rd_wait", bus.rd_wait, k != 8);
      tick();
      if (k == 8) begin
        chkp("t5_tx_rd", bus.tx_packet, pk(32'h50));
        r = r + 1;
      end else begin
        chkp("t5_tx_wr", bus.tx_packet, pk(w));
        w = w + 1;
      end
    end
    bus.wr_access = 1'b0;
    bus.wr_lock   = 1'b0;
    bus.rd_packet = pk(r);
    tick();
    chkp("t5_tail_rd", bus.tx_packet, pk(32'h51));
    bus.rd_access = 1'b0;
    tick();

    // ---- reset in beat 2 of a locked burst
    do_reset();
    bus.wr_access = 1'b1;
    bus.wr_lock   = 1'b1;
    bus.wr_packet = pk(32'h70);
    tick();
    chkp("t6_beat1", bus.tx_packet, pk(32'h70));
    bus.wr_packet = pk(32'h71);
    rst = 1'b1;
    #1;
    chk1("t6_wr_wait_rst", bus.wr_wait, 1'b1);
    tick();
    chk1("t6_tx_access_rst", bus.tx_access, 1'b0);
    chkp("t6_tx_packet_rst", bus.tx_packet, pk(32'h0));
    rst = 1'b0;
    bus.wr_access = 1'b0;
    bus.wr_lock   = 1'b0;
    bus.rd_access = 1'b1;
    bus.rd_packet = pk(32'h80);
    #1;
    chk1("t6_rd_wait_arb", bus.rd_wait, 1'b0);
    tick();
    chkp("t6_tx_rd", bus.tx_packet, pk(32'h80));
    bus.rd_access = 1'b0;
    bus.wr_access = 1'b1;
    bus.wr_packet = pk(32'hA1);
    #1;
    chk1("t6_wr_wait_a1", bus.wr_wait, 1'b0);
    tick();
    bus.wr_access = 1'b0;
    chk1("t6_tx_access_a1", bus.tx_access, 1'b1);
    chkp("t6_tx_packet_a1", bus.tx_packet, pk(32'hA1));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/esaxi_mesh_arb.md
ESAXI_MESH_ARB -- requirements
Module: esaxi_mesh_arb

Interface
REQ-001 SHALL have clk, input, 1: clock; all state updates on rising edge.
REQ-002 SHALL have rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have parameter PW, default 104: eMesh packet width.
REQ-004 SHALL have parameter MAX_HOLD, default 8: max consecutive write grants while a read is pending.
REQ-005 SHALL have wr_access, input, 1: write-request packet valid (from AXI slave write path).
REQ-006 SHALL have wr_packet, input, PW: write-request packet.
REQ-007 SHALL have wr_lock, input, 1: sampled with an accepted write; more beats of the same burst follow.
REQ-008 SHALL have wr_wait, output, 1: write source must hold its packet.
REQ-009 SHALL have rd_access, input, 1: read-request packet valid.
REQ-010 SHALL have rd_packet, input, PW: read-request packet.
REQ-011 SHALL have rd_wait, output, 1: read source must hold its packet.
REQ-012 SHALL have tx_access, output, 1: registered merged packet valid.
REQ-013 SHALL have tx_packet, output, PW: registered merged packet.
REQ-014 SHALL have tx_wait, input, 1: downstream backpressure.

Function
REQ-015 An input transfer SHALL occur when x_access=1 and x_wait=0 in the same cycle; an output transfer when tx_access=1 and tx_wait=0.
REQ-016 load = (tx_access=0) or (tx_wait=0); the output register SHALL accept a new packet only when load=1.
REQ-017 At most one input SHALL be granted per cycle; the granted packet SHALL appear on tx_packet with tx_access=1 exactly one cycle after acceptance (latency 1).
REQ-018 wr_wait and rd_wait SHALL be combinational: x_wait = not(load and grant==x); a non-requesting input's wait SHALL be 1 unless it would be granted.
REQ-019 With load=1 and no access, tx_access SHALL go 0 next cycle; tx_packet SHALL hold its last value.
REQ-020 While tx_wait=1 and tx_access=1, tx_access and tx_packet SHALL remain stable.
REQ-021 States SHALL be ARB and WLOCK.
REQ-022 In ARB, grant SHALL be round-robin: single requester wins; on contention the input not granted last wins; last-grant pointer updates only on an accepted transfer.
REQ-023 ARB -> WLOCK when a write is accepted with wr_lock=1; WLOCK -> ARB when a write is accepted with wr_lock=0.
REQ-024 In WLOCK, only the write input SHALL be granted, with rd_wait=1, except under REQ-026.
REQ-025 A 4-bit hold counter SHALL count consecutive accepted writes while rd_access=1; it SHALL clear on any accepted read or when rd_access=0; it saturates at MAX_HOLD.
REQ-026 When hold counter == MAX_HOLD and rd_access=1, the next grant SHALL go to read even in WLOCK; the state stays WLOCK and returns to write-only after that read.
REQ-027 Simultaneous load=1 and tx_wait deassertion SHALL drain the old packet and load the new one in the same cycle with no loss or duplication.
REQ-028 Packets SHALL pass through unmodified; no field of the packet is decoded.

Reset
REQ-029 On rst=1: tx_access=0, tx_packet=0, state=ARB, last-grant pointer=read (so write wins first contention), hold counter=0.
REQ-030 During rst=1 wr_wait=1 and rd_wait=1; no transfer is accepted in a reset cycle.
REQ-031 Reset mid-burst SHALL discard the output register and lock state without producing a partial tx_access.

Structure
REQ-032 Shared package esaxi_pkg SHALL hold PW, MAX_HOLD default, and the state enum (ARB, WLOCK).
REQ-033 One sub-module esaxi_rr2 (2-way round-robin grant with pointer) SHALL be used; the output register and lock FSM stay in the top.

Verification
REQ-034 Reset, then wr_access=1 packet 0xA1 alone, tx_wait=0 -> wr_wait=0 in cycle 0; tx_access=1, tx_packet=0xA1 in cycle 1.
REQ-035 wr and rd both asserting continuously (0x10.., 0x20..), wr_lock=0 -> grants alternate W,R,W,R starting with W; tx sequence matches.
REQ-036 tx_wait=1 for 3 cycles with packet 0x55 in register -> tx_packet=0x55 stable, wr_wait=rd_wait=1; on release, next packet loads same cycle as drain.
REQ-037 Write burst of 4 beats with wr_lock=1,1,1,0 while rd_access=1 -> 4 writes back-to-back, then read; state returns to ARB.
REQ-038 Locked burst of 12 beats with rd_access=1 and MAX_HOLD=8 -> 8 writes, 1 read, 4 writes; no packet dropped or duplicated.
REQ-039 rst asserted in beat 2 of a locked burst -> next cycle tx_access=0, state=ARB; first request after reset handled per REQ-034.
